// File: rtl/logic_op_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : logic_op_arbiter
// Purpose  : Round-robin arbiter that shares one registered AND/OR/XOR/ANDN
//            unit between two requesters over a tagged response channel.
// Option   : LOGIC_ARB_GRANT_CNT_EN enables the saturating 16-bit grant_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module logic_op_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  input  logic [1:0]       r0_op,
  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  input  logic [1:0]       r1_op,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_data,
  output logic [15:0]      grant_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic             id_q, id_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_id_q, resp_id_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;

  logic             w_gnt0, w_gnt1, w_accept;
  logic [WIDTH-1:0] w_result;

  // On contention the requester that did not win last time is favoured.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (state_q == IDLE) begin
      if (r0_valid && r1_valid) begin
        w_gnt0 = last_grant_q;
        w_gnt1 = ~last_grant_q;
      end else begin
        w_gnt0 = r0_valid;
        w_gnt1 = r1_valid;
      end
    end
  end

  assign r0_ready = w_gnt0;
  assign r1_ready = w_gnt1;
  assign w_accept = w_gnt0 | w_gnt1;

  always_comb begin
    w_result = '0;
    unique case (op_q)
      2'b00:   w_result = a_q & b_q;
      2'b01:   w_result = a_q | b_q;
      2'b10:   w_result = a_q ^ b_q;
      default: w_result = a_q & ~b_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    id_d         = id_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    unique case (state_q)
      IDLE: begin
        if (w_accept) begin
          state_d      = EXEC;
          id_d         = w_gnt1;
          last_grant_d = w_gnt1;
          a_d          = w_gnt1 ? r1_a  : r0_a;
          b_d          = w_gnt1 ? r1_b  : r0_b;
          op_d         = w_gnt1 ? r1_op : r0_op;
        end
      end
      EXEC: begin
        state_d      = DONE;
        resp_data_d  = w_result;
        resp_id_d    = id_q;
        resp_valid_d = 1'b1;
      end
      DONE: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= 2'b00;
      id_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      id_q         <= id_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;

`ifdef LOGIC_ARB_GRANT_CNT_EN
  logic [15:0] grant_cnt_q, grant_cnt_d;

  always_comb begin
    grant_cnt_d = grant_cnt_q;
    if (w_accept && (grant_cnt_q != 16'hFFFF)) begin
      grant_cnt_d = grant_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_q <= 16'h0000;
    end else begin
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign grant_cnt = grant_cnt_q;
`else
  assign grant_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire
